counter_sram_reader: RTL and testbench

- System-bus side consumer of the counter sample buffer. Drives the read port (port B) of the counter's dual-port SRAM.
- Offers two access paths:
  - a random-access memory window;
  - a ring-buffer FIFO view (POP register) that advances a read pointer against the counter writer's write pointer.
- Exports the read pointer so the writer can detect full. Sits between the system-bus slave and the SRAM.

---
 rtl/counter_sram_reader.sv | 131 +++++++++++++
 tb/tb_counter_sram_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sram_reader.sv
// Bus-side reader of the counter sample SRAM: register block, memory window and ring-buffer POP.
// Latency: register/error/empty-POP ack one cycle after the strobe; SRAM-backed reads ack three cycles after.
// Backpressure: none; one request outstanding, and strobes seen outside IDLE are dropped.
module counter_sram_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [31:0]           i_sys_addr,
  input  logic                  i_sys_wen,
  input  logic                  i_sys_ren,
  input  logic [31:0]           i_sys_wdata,
  output logic [31:0]           o_sys_rdata,
  output logic                  o_sys_ack,
  output logic                  o_sys_err,
  input  logic [ADDR_WIDTH:0]   i_wr_ptr,
  output logic [ADDR_WIDTH:0]   o_rd_ptr,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_we,
  input  logic [DATA_WIDTH-1:0] i_sram_data
);
  localparam int PW = ADDR_WIDTH + 1;

  localparam logic [19:0] REG_STATUS = 20'h00000;
  localparam logic [19:0] REG_RD_PTR = 20'h00004;
  localparam logic [19:0] REG_POP    = 20'h00008;
  localparam logic [19:0] REG_CLEAR  = 20'h0000C;
  localparam logic [19:0] WIN_BASE   = 20'h10000;
  localparam logic [31:0] EMPTY_WORD = 32'h4000_0000;

  typedef enum logic [1:0] {IDLE, SRAM_ADDR, SRAM_WAIT, RESP} state_t;

  state_t        state;
  logic [PW-1:0] rd_ptr;
  logic          pop_op;
  logic [PW-1:0] fill;
  logic          empty;
  logic          full;
  logic [19:0]   reg_addr;
  logic [19:0]   win_off;
  logic          win_hit;
  logic [31:0]   status_word;
  logic          unused_bus;

  assign unused_bus = ^{i_sys_addr[31:20], i_sys_wdata};

  assign reg_addr = i_sys_addr[19:0];
  assign win_off  = reg_addr - WIN_BASE;
  assign win_hit  = (reg_addr >= WIN_BASE) && (win_off[1:0] == 2'b00) &&
                    (win_off[19:2] < 18'(DEPTH));

  // Occupancy relies on modular subtraction of the wrap-bit pointers.
  assign fill  = i_wr_ptr - rd_ptr;
  assign empty = (fill == '0);
  assign full  = (fill == PW'(DEPTH));

  always_comb begin
    status_word         = '0;
    status_word[PW-1:0] = fill;
    status_word[30]     = empty;
    status_word[31]     = full;
  end

  assign o_rd_ptr  = rd_ptr;
  assign o_sram_we = 1'b0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      pop_op      <= 1'b0;
      o_sram_addr <= '0;
      o_sys_rdata <= '0;
      o_sys_ack   <= 1'b0;
      o_sys_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_sys_ack <= 1'b0;
          if (i_sys_wen || i_sys_ren) begin
            state       <= RESP;
            o_sys_ack   <= 1'b1;
            o_sys_err   <= 1'b0;
            o_sys_rdata <= '0;
            pop_op      <= 1'b0;
            if (i_sys_wen && i_sys_ren) begin
              o_sys_err <= 1'b1;
            end else if (i_sys_ren && reg_addr == REG_STATUS) begin
              o_sys_rdata <= status_word;
            end else if (i_sys_ren && reg_addr == REG_RD_PTR) begin
              o_sys_rdata <= 32'(rd_ptr);
            end else if (i_sys_ren && reg_addr == REG_POP) begin
              if (empty) begin
                o_sys_rdata <= EMPTY_WORD;
              end else begin
                state       <= SRAM_ADDR;
                o_sys_ack   <= 1'b0;
                o_sram_addr <= rd_ptr[ADDR_WIDTH-1:0];
                pop_op      <= 1'b1;
              end
            end else if (i_sys_wen && reg_addr == REG_CLEAR) begin
              rd_ptr <= i_wr_ptr;
            end else if (i_sys_ren && win_hit) begin
              state       <= SRAM_ADDR;
              o_sys_ack   <= 1'b0;
              o_sram_addr <= win_off[ADDR_WIDTH+1:2];
            end else begin
              o_sys_err <= 1'b1;
            end
          end
        end
        SRAM_ADDR: state <= SRAM_WAIT;
        SRAM_WAIT: begin
          // Pointer advances only once the popped sample is captured.
          o_sys_rdata <= 32'(i_sram_data);
          o_sys_ack   <= 1'b1;
          o_sys_err   <= 1'b0;
          state       <= RESP;
          if (pop_op) rd_ptr <= rd_ptr + PW'(1);
        end
        RESP: begin
          o_sys_ack <= 1'b0;
          pop_op    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_counter_sram_reader.sv
// Scoreboard bench: a behavioural model predicts every bus response; a monitor checks each ack.
module tb_counter_sram_reader;
  localparam int AW = 12;
  localparam int DW = 18;
  localparam int DEPTH = 4096;
  localparam int PMOD = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   sys_addr = '0;
  logic          sys_wen = 1'b0;
  logic          sys_ren = 1'b0;
  logic [31:0]   sys_wdata = '0;
  logic [31:0]   sys_rdata;
  logic          sys_ack;
  logic          sys_err;
  logic [AW:0]   wr_ptr = '0;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] sram_addr;
  logic          sram_we;
  logic [DW-1:0] sram_q = '0;

  logic [DW-1:0] mem [DEPTH];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int m_rd = 0;
  logic prev_ack = 1'b0;

  typedef struct {
    logic [31:0] d;
    logic        err;
    int          cyc;
    int          sa;
  } exp_t;
  exp_t q[$];

  counter_sram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rstn(rst_n),
    .i_sys_addr(sys_addr), .i_sys_wen(sys_wen), .i_sys_ren(sys_ren), .i_sys_wdata(sys_wdata),
    .o_sys_rdata(sys_rdata), .o_sys_ack(sys_ack), .o_sys_err(sys_err),
    .i_wr_ptr(wr_ptr), .o_rd_ptr(rd_ptr),
    .o_sram_addr(sram_addr), .o_sram_we(sram_we), .i_sram_data(sram_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) sram_q <= mem[sram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the oldest prediction, including its arrival cycle.
  always @(negedge clk) begin
    if (rst_n && sys_ack) begin
      chk("ack_single_cycle", 32'(prev_ack), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rdata", sys_rdata, e.d);
        chk("err", 32'(sys_err), 32'(e.err));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.sa >= 0) chk("sram_addr_at_ack", 32'(sram_addr), 32'(e.sa));
      end
    end
    prev_ack <= rst_n && sys_ack;
  end

  function automatic int cur_fill();
    return (int'(wr_ptr) - m_rd + PMOD) % PMOD;
  endfunction

  // Behavioural model of one bus request, evaluated with the pointers of the strobe cycle.
  task automatic model(input logic [31:0] addr, input logic wen, input logic ren,
                       output logic [31:0] d, output logic err, output int lat, output int sa);
    int a;
    int f;
    a = int'(addr[19:0]);
    f = cur_fill();
    d = '0; err = 1'b0; lat = 1; sa = -1;
    if (wen && ren) begin
      err = 1'b1;
    end else if (ren && a == 0) begin
      d = 32'(f);
      if (f == 0) d[30] = 1'b1;
      if (f == DEPTH) d[31] = 1'b1;
    end else if (ren && a == 4) begin
      d = 32'(m_rd);
    end else if (ren && a == 8) begin
      if (f == 0) begin
        d = 32'h4000_0000;
      end else begin
        sa = m_rd % DEPTH;
        d = 32'(mem[sa]);
        lat = 3;
        m_rd = (m_rd + 1) % PMOD;
      end
    end else if (wen && a == 12) begin
      m_rd = int'(wr_ptr);
    end else if (ren && a >= 32'h10000 && a < 32'h10000 + 4 * DEPTH && a % 4 == 0) begin
      sa = (a - 32'h10000) / 4;
      d = 32'(mem[sa]);
      lat = 3;
    end else begin
      err = 1'b1;
    end
  endtask

  task automatic adv_wr(input int n);
    for (int i = 0; i < n; i++) begin
      mem[int'(wr_ptr) % DEPTH] = DW'($urandom);
      wr_ptr = wr_ptr + 1'b1;
    end
  endtask

  // Issues one request from a negedge, then waits for its ack and for the FSM to return to IDLE.
  task automatic issue(input logic [31:0] addr, input logic wen, input logic ren, input int adv_mid);
    exp_t e;
    int lat;
    int sa;
    bit got;
    model(addr, wen, ren, e.d, e.err, lat, sa);
    e.cyc = cyc + lat;
    e.sa = sa;
    q.push_back(e);
    sys_addr = addr; sys_wen = wen; sys_ren = ren; sys_wdata = $urandom;
    @(negedge clk);
    sys_wen = 1'b0; sys_ren = 1'b0;
    if (lat == 3) chk("sram_addr_cycle1", 32'(sram_addr), 32'(sa));
    if (adv_mid > 0) adv_wr(adv_mid);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (sys_ack) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      if (q.size() > 0) void'(q.pop_front());
    end
    @(negedge clk);
    chk("rd_ptr", 32'(rd_ptr), 32'(m_rd));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a20;
    logic wen;
    logic ren;
    int r;
    int adv;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rdata", sys_rdata, 32'd0);
    chk("rst_ack", 32'(sys_ack), 32'd0);
    chk("rst_err", 32'(sys_err), 32'd0);
    chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Window read
    mem[5] = 18'h2ABCD;
    issue(32'h0001_0014, 1'b0, 1'b1, 0);

    // Reset in the middle of a window read: no ack may appear
    sys_addr = 32'h0001_0014; sys_ren = 1'b1;
    @(negedge clk);
    sys_ren = 1'b0;
    rst_n = 1'b0;
    m_rd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_ack", 32'(sys_ack), 32'd0);
    end
    chk("midrst_rdata", sys_rdata, 32'd0);
    chk("midrst_rd_ptr", 32'(rd_ptr), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_ack", 32'(sys_ack), 32'd0);
    end

    // FIFO: three samples, then empty POP and STATUS
    mem[0] = 18'd10; mem[1] = 18'd11; mem[2] = 18'd12;
    wr_ptr = 13'd3;
    repeat (4) issue(32'h0000_0008, 1'b0, 1'b1, 0);
    chk("fifo_rd_ptr", 32'(rd_ptr), 32'd3);
    issue(32'h0000_0000, 1'b0, 1'b1, 0);

    // Full: rd=0, wr=4096
    wr_ptr = '0;
    issue(32'h0000_000C, 1'b1, 1'b0, 0);
    adv_wr(DEPTH);
    issue(32'h0000_0000, 1'b0, 1'b1, 0);

    // Wrap: rd=8191, wr=0
    wr_ptr = 13'd8191;
    issue(32'h0000_000C, 1'b1, 1'b0, 0);
    wr_ptr = '0;
    mem[4095] = 18'd7;
    issue(32'h0000_0008, 1'b0, 1'b1, 0);
    chk("wrap_rd_ptr", 32'(rd_ptr), 32'd0);

    // CLEAR
    wr_ptr = 13'd100;
    issue(32'h0000_000C, 1'b1, 1'b0, 0);
    chk("clear_rd_ptr", 32'(rd_ptr), 32'd100);
    issue(32'h0000_0000, 1'b0, 1'b1, 0);

    // Error cases
    issue(32'h0001_0000, 1'b1, 1'b0, 0);
    issue(32'h0000_000C, 1'b0, 1'b1, 0);
    issue(32'h0000_0020, 1'b0, 1'b1, 0);
    issue(32'h0000_0008, 1'b1, 1'b1, 0);
    chk("err_rd_ptr_kept", 32'(rd_ptr), 32'd100);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r < 6) adv_wr($urandom_range(0, (DEPTH - cur_fill()) < 40 ? DEPTH - cur_fill() : 40));
      else if (r == 6) adv_wr(DEPTH - cur_fill());
      case ($urandom_range(0, 11))
        0: a20 = 32'h0;
        1: a20 = 32'h4;
        2, 3, 4: a20 = 32'h8;
        5: a20 = 32'hC;
        6, 7: a20 = 32'h10000 + 4 * $urandom_range(0, DEPTH - 1);
        8: a20 = 32'h10000 + $urandom_range(0, 32'h3FFF);
        9: a20 = $urandom_range(4, 32'h3FFF) * 4;
        10: a20 = 32'h14000 + $urandom_range(0, 32'hFF);
        default: a20 = $urandom_range(0, 32'hFFFFF);
      endcase
      r = $urandom_range(0, 19);
      wen = (r <= 3);
      ren = (r == 0) || (r > 3);
      adv = 0;
      if (a20 == 32'h8 && ren && !wen && cur_fill() > 0 && $urandom_range(0, 1) == 1)
        adv = $urandom_range(0, DEPTH - cur_fill());
      issue(($urandom & 32'hFFF0_0000) | a20, wen, ren, adv);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
